// File: rtl/scc_dmem_dump_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_dump_pkg : shared types/constants for the data-memory dump ctrl  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package scc_dump_pkg;

  localparam int unsigned WORD_BYTES          = 4;
  localparam int          DEFAULT_DEPTH_WORDS = 16384;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/scc_dmem_dump_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_dmem_dump_ctrl_if : core, memory and record-stream bus bundle     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface scc_dmem_dump_ctrl_if;

  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;

  // Controller side.
  modport master (
    input  core_addr, core_wdata, core_we, core_re, mem_rdata, rec_ready,
    output core_rdata, mem_addr, mem_wdata, mem_we, mem_re,
           rec_valid, rec_addr, rec_data
  );

  // Core / memory / record-sink side.
  modport slave (
    output core_addr, core_wdata, core_we, core_re, mem_rdata, rec_ready,
    input  core_rdata, mem_addr, mem_wdata, mem_we, mem_re,
           rec_valid, rec_addr, rec_data
  );

endinterface
`default_nettype wire

// File: rtl/scc_dmem_dump_ctrl_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_dmem_port_mux : selects core or dump engine onto the memory port |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module scc_dmem_port_mux (
  input  logic        dump_sel,
  input  logic        dump_re,
  input  logic [31:0] dump_addr,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  // While dumping the core is fully locked out; writes can never reach memory.
  assign mem_addr   = dump_sel ? dump_addr : core_addr;
  assign mem_wdata  = dump_sel ? 32'h0     : core_wdata;
  assign mem_we     = dump_sel ? 1'b0      : core_we;
  assign mem_re     = dump_sel ? dump_re   : core_re;
  assign core_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: rtl/scc_dmem_dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_dmem_dump_ctrl : streams every data-memory word out on halt      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module scc_dmem_dump_ctrl
  import scc_dump_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  halt_f,
  scc_dmem_dump_ctrl_if.master  bus,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int             IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  dump_state_e      state;
  dump_state_e      state_next;
  logic [IDX_W-1:0] index;
  logic [31:0]      dump_addr;
  logic [31:0]      rec_addr_q;
  logic [31:0]      rec_data_q;
  logic             last_word;
  logic             handshake;
  logic             dump_sel;
  logic             dump_re;

  assign dump_addr = BASE_ADDR + (32'(index) * 32'(WORD_BYTES));
  assign last_word = (index == LAST_IDX);
  assign handshake = (state == ST_EMIT) && bus.rec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (halt_f) state_next = ST_READ;
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: state_next = ST_EMIT;
      ST_EMIT: if (handshake) state_next = last_word ? ST_DONE : ST_READ;
      ST_DONE: if (!halt_f) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dump_sel      = 1'b1;
    dump_re       = 1'b0;
    dump_busy     = 1'b0;
    dump_done     = 1'b0;
    bus.rec_valid = 1'b0;
    case (state)
      ST_IDLE: dump_sel = 1'b0;
      ST_READ: begin
        dump_re   = 1'b1;
        dump_busy = 1'b1;
      end
      ST_WAIT: dump_busy = 1'b1;
      ST_EMIT: begin
        dump_busy     = 1'b1;
        bus.rec_valid = 1'b1;
      end
      ST_DONE: dump_done = 1'b1;
      default: dump_sel = 1'b0;
    endcase
  end

  // Read data lands during WAIT, one cycle after the READ strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      index      <= '0;
      rec_addr_q <= 32'h0;
      rec_data_q <= 32'h0;
    end else if (clk_en) begin
      if (state == ST_IDLE && halt_f) begin
        index <= '0;
      end
      if (state == ST_WAIT) begin
        rec_addr_q <= dump_addr;
        rec_data_q <= bus.mem_rdata;
      end
      if (handshake && !last_word) begin
        index <= index + 1'b1;
      end
    end
  end

  assign bus.rec_addr = rec_addr_q;
  assign bus.rec_data = rec_data_q;

  scc_dmem_port_mux u_port_mux (
    .dump_sel   (dump_sel),
    .dump_re    (dump_re),
    .dump_addr  (dump_addr),
    .core_addr  (bus.core_addr),
    .core_wdata (bus.core_wdata),
    .core_we    (bus.core_we),
    .core_re    (bus.core_re),
    .core_rdata (bus.core_rdata),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .mem_we     (bus.mem_we),
    .mem_re     (bus.mem_re),
    .mem_rdata  (bus.mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_scc_dmem_dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scc_dmem_dump_ctrl : record-stream model checks for the dump ctrl |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_scc_dmem_dump_ctrl;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic halt_f;
  logic dump_busy;
  logic dump_done;

  scc_dmem_dump_ctrl_if bus ();

  scc_dmem_dump_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .halt_f    (halt_f),
    .bus       (bus),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous write, registered read data.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[11:2]];
  end

  logic [31:0] shadow    [0:DEPTH-1];
  logic [31:0] seen_addr [0:DEPTH-1];
  logic [31:0] seen_data [0:DEPTH-1];
  int n_cmp = 0;
  int n_err = 0;
  int exp_idx = 0;
  int total_hs = 0;
  logic stall_prev = 1'b0;
  logic done_prev = 1'b0;
  logic [31:0] held_addr, held_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each dump is the words 0..DEPTH-1 in order, addr = 4*i, data = shadow[i].
  always @(negedge clk) begin
    if (rst) begin
      exp_idx    = 0;
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, bus.rec_valid}, 32'd1);
        chk("stall_addr", bus.rec_addr, held_addr);
        chk("stall_data", bus.rec_data, held_data);
      end
      if (dump_done && !done_prev) begin
        chk("records_per_dump", exp_idx, DEPTH);
        exp_idx = 0;
      end
      if (bus.rec_valid) chk("busy_with_valid", {31'b0, dump_busy}, 32'd1);
      if (bus.rec_valid && bus.rec_ready && clk_en) begin
        if (exp_idx >= DEPTH) begin
          chk("extra_record", exp_idx, DEPTH - 1);
        end else begin
          chk("rec_addr", bus.rec_addr, 32'(exp_idx) * 32'd4);
          chk("rec_data", bus.rec_data, shadow[exp_idx]);
          seen_addr[exp_idx] = bus.rec_addr;
          seen_data[exp_idx] = bus.rec_data;
        end
        exp_idx++;
        total_hs++;
        stall_prev = 1'b0;
      end else if (bus.rec_valid) begin
        stall_prev = 1'b1;
        held_addr  = bus.rec_addr;
        held_data  = bus.rec_data;
      end else begin
        stall_prev = 1'b0;
      end
      done_prev = dump_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int base;
    rst = 1'b1; clk_en = 1'b1; halt_f = 1'b0;
    bus.core_addr = '0; bus.core_wdata = '0; bus.core_we = 1'b0; bus.core_re = 1'b0;
    bus.rec_ready = 1'b0;
    step(); step();
    chk("rst_rec_valid", {31'b0, bus.rec_valid}, 32'd0);
    chk("rst_rec_addr", bus.rec_addr, 32'd0);
    chk("rst_rec_data", bus.rec_data, 32'd0);
    chk("rst_busy", {31'b0, dump_busy}, 32'd0);
    chk("rst_done", {31'b0, dump_done}, 32'd0);
    rst = 1'b0;

    // Preload through the core pass-through path.
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] lo;
      lo = 16'(i);
      shadow[i] = {lo, ~lo};
      if (i == 32'h220) shadow[i] = 32'h0000_0010;
      if (i == 32'h223) shadow[i] = 32'h0f0f_0f0f;
      bus.core_we = 1'b1; bus.core_addr = 32'(i) * 32'd4; bus.core_wdata = shadow[i];
      step();
    end
    bus.core_addr = 32'h890; bus.core_wdata = 32'h100;
    shadow[32'h224] = 32'h0000_0100;
    step();
    bus.core_we = 1'b0; bus.core_re = 1'b1;
    step();
    bus.core_re = 1'b0;
    chk("core_read_890", bus.core_rdata, 32'h0000_0100);
    bus.core_re = 1'b1; bus.core_addr = 32'h88c;
    step();
    bus.core_re = 1'b0;
    chk("core_read_88c", bus.core_rdata, 32'h0f0f_0f0f);

    // Dump 1: ready held high, full throughput.
    halt_f = 1'b1; bus.rec_ready = 1'b1;
    cyc = 0;
    while (!dump_done && cyc < 5000) begin step(); cyc++; end
    chk("dump1_cycles", cyc, 3 * DEPTH + 1);
    chk("dump1_total", total_hs, DEPTH);
    chk("rec_220_addr", seen_addr[32'h220], 32'h0000_0880);
    chk("rec_220_data", seen_data[32'h220], 32'h0000_0010);
    chk("rec_223_addr", seen_addr[32'h223], 32'h0000_088c);
    chk("rec_223_data", seen_data[32'h223], 32'h0f0f_0f0f);
    chk("rec_224_data", seen_data[32'h224], 32'h0000_0100);

    // Halt held after DONE: no retrigger.
    repeat (20) step();
    chk("done_held", {31'b0, dump_done}, 32'd1);
    chk("done_not_busy", {31'b0, dump_busy}, 32'd0);
    chk("no_second_dump", total_hs, DEPTH);
    halt_f = 1'b0;
    step();
    chk("done_cleared", {31'b0, dump_done}, 32'd0);

    // Dump 2: ready 1-of-4, halt dropped mid-dump.
    halt_f = 1'b1;
    cyc = 0;
    while (!dump_done && cyc < 20000) begin
      bus.rec_ready = ((cyc % 4) == 3);
      if (cyc == 100) halt_f = 1'b0;
      step();
      cyc++;
    end
    chk("dump2_done_seen", {31'b0, dump_done}, 32'd1);
    chk("dump2_total", total_hs, 2 * DEPTH);
    step();
    chk("dump2_back_idle", {31'b0, dump_done}, 32'd0);

    // clk_en freeze mid-EMIT.
    bus.rec_ready = 1'b0; halt_f = 1'b1;
    cyc = 0;
    while (!bus.rec_valid && cyc < 10) begin step(); cyc++; end
    chk("frz_first_addr", bus.rec_addr, 32'h0000_0000);
    chk("frz_first_data", bus.rec_data, 32'h0000_ffff);
    base = total_hs;
    clk_en = 1'b0; bus.rec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frz_valid", {31'b0, bus.rec_valid}, 32'd1);
      chk("frz_addr", bus.rec_addr, 32'h0000_0000);
    end
    chk("frz_no_hs", total_hs, base);
    clk_en = 1'b1;
    step();
    chk("frz_released", {31'b0, bus.rec_valid}, 32'd0);

    // Reset at record 5, then restart from address 0.
    cyc = 0;
    while (total_hs != base + 5 && cyc < 100) begin step(); cyc++; end
    chk("reached_rec5", total_hs, base + 5);
    rst = 1'b1; halt_f = 1'b0;
    step();
    rst = 1'b0;
    chk("rst2_rec_valid", {31'b0, bus.rec_valid}, 32'd0);
    chk("rst2_rec_addr", bus.rec_addr, 32'd0);
    chk("rst2_rec_data", bus.rec_data, 32'd0);
    chk("rst2_busy", {31'b0, dump_busy}, 32'd0);
    chk("rst2_done", {31'b0, dump_done}, 32'd0);
    base = total_hs;
    halt_f = 1'b1;
    cyc = 0;
    while (!bus.rec_valid && cyc < 10) begin step(); cyc++; end
    chk("restart_addr", bus.rec_addr, 32'h0000_0000);
    cyc = 0;
    while (!dump_done && cyc < 5000) begin step(); cyc++; end
    chk("dump3_total", total_hs - base, DEPTH);
    chk("dump3_done", {31'b0, dump_done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
